// File: rtl/tron_bus_pkg.sv
// Shared types and constants for the core-bus memory responder.
package tron_bus_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int BUS_ADDR_W = 16;
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } resp_state_t;

  // True when any bus address bit above the RAM index is set.
  function automatic logic addr_out_of_range(input logic [BUS_ADDR_W-1:0] addr,
                                             input int aw);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUS_ADDR_W; i++) begin
      if (i >= aw && addr[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_word_ram.sv
// Single-port word RAM: synchronous write, registered read.
module sp_word_ram #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write or read one word per enabled cycle; the read register holds between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the core bus: one request at a time, configurable
// wait states, range check, and a valid/ready response.
module bus_mem_responder
  import tron_bus_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("bus_mem_responder: WAIT_STATES must be within 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  range_err;
  logic                  ram_en;
  logic [DATA_W-1:0]     ram_rdata;

  assign range_err = addr_out_of_range(addr_q, ADDR_W);

  // Next-state, wait counter and request latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: aborts to IDLE immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches; only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Out-of-range requests never touch the RAM.
  assign ram_en = (state_q == ACCESS) && !range_err;

  sp_word_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (wr_q),
    .addr (addr_q[ADDR_W-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Outputs decode from registered state, so they change only on clock or reset edges.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && range_err;
  assign rsp_rdata = (rsp_valid && !wr_q && !range_err) ? ram_rdata : '0;

endmodule
